// File: rtl/io_bus_master.sv
// io_bus_master: core-side master for the memory-mapped IO system bus.
// Core requests are queued in a small FIFO. They are issued one at a time as
// single-cycle n2m pulses. Load data is extracted from the returned bus line,
// and each request gets one tagged response, returned in request order.
// Optional feature: define IO_BUS_MASTER_TIMEOUT_EN to bound the read wait to
// TIMEOUT_CYCLES cycles; a timed-out read returns resp_error=1.
module io_bus_master #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BUS_WIDTH      = 512,
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_WIDTH      = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_data,
    input  logic [TAG_WIDTH-1:0]     req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [TAG_WIDTH-1:0]     resp_tag,
    output logic                     resp_is_write,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     resp_error,
    output logic [ADDRESS_WIDTH-1:0] n2m_request_address,
    output logic [BUS_WIDTH-1:0]     n2m_request_data,
    output logic                     n2m_request_read,
    output logic                     n2m_request_write,
    output logic                     mc_avail_o,
    input  logic                     m2n_request_available,
    input  logic                     m2n_response_valid,
    input  logic [ADDRESS_WIDTH-1:0] m2n_response_address,
    input  logic [BUS_WIDTH-1:0]     m2n_response_data
);
    localparam int WORDS = BUS_WIDTH / DATA_WIDTH;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int OFS   = $clog2(DATA_WIDTH / 8);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                     is_write;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
        logic [TAG_WIDTH-1:0]     tag;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    req_t                r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic                r_up;
    state_t              r_state;
    req_t                r_cur;
    logic [TAG_WIDTH-1:0]  r_resp_tag;
    logic                  r_resp_is_write;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_error;

    logic w_empty, w_full, w_push, w_pop;
    req_t w_head;
    logic [IDX_W-1:0] w_idx;
    logic [WORDS-1:0][DATA_WIDTH-1:0] w_resp_words;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    // r_up keeps req_ready low while reset is held and for the first edge after
    assign req_ready = r_up & ~w_full;
    assign w_push    = req_valid & req_ready;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    assign w_head    = r_fifo[r_rd_ptr];

    assign w_idx        = r_cur.addr[OFS +: IDX_W];
    assign w_resp_words = m2n_response_data;

    assign resp_valid          = (r_state == S_RESP);
    assign resp_tag            = r_resp_tag;
    assign resp_is_write       = r_resp_is_write;
    assign resp_data           = r_resp_data;
    assign resp_error          = r_resp_error;
    assign n2m_request_address = r_cur.addr;
    assign n2m_request_data    = {WORDS{r_cur.data}};
    assign n2m_request_read    = (r_state == S_ISSUE) & m2n_request_available & ~r_cur.is_write;
    assign n2m_request_write   = (r_state == S_ISSUE) & m2n_request_available &  r_cur.is_write;
    assign mc_avail_o          = (r_state == S_WAIT);

    // The echoed response address carries nothing the master needs.
    logic w_unused_ok;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
    assign w_unused_ok = ^m2n_response_address;
`else
    assign w_unused_ok = ^m2n_response_address ^ (TIMEOUT_CYCLES != 0);
`endif

    // Request queue payload; no reset needed, occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= '{req_is_write, req_address, req_data, req_tag};
    end

    // Queue pointers and occupancy; push and pop may coincide in one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_up     <= 1'b0;
        end else begin
            r_up <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IO_BUS_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_to_cnt;
`endif

    // Bus sequencer: one outstanding request, registered response fields
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_cur           <= '0;
            r_resp_tag      <= '0;
            r_resp_is_write <= 1'b0;
            r_resp_data     <= '0;
            r_resp_error    <= 1'b0;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
            r_to_cnt        <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_head.addr[1:0] != 2'b00) begin
                            // misaligned: answer with an error, never touch the bus
                            r_resp_tag      <= w_head.tag;
                            r_resp_is_write <= w_head.is_write;
                            r_resp_data     <= '0;
                            r_resp_error    <= 1'b1;
                            r_state         <= S_RESP;
                        end else begin
                            r_cur   <= w_head;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (m2n_request_available) begin
                        r_resp_tag      <= r_cur.tag;
                        r_resp_is_write <= r_cur.is_write;
                        r_resp_data     <= '0;
                        r_resp_error    <= 1'b0;
                        // writes are posted; reads wait for the line
                        r_state         <= r_cur.is_write ? S_RESP : S_WAIT;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
                        r_to_cnt        <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (m2n_response_valid) begin
                        r_resp_data  <= w_resp_words[w_idx];
                        r_resp_error <= 1'b0;
                        r_state      <= S_RESP;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
                    end else if (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // last allowed wait cycle passed without data
                        r_resp_data  <= '0;
                        r_resp_error <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (resp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
